// File: rtl/icache_pkg.sv
// Shared types and helpers for the I-cache line refill engine.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } refill_state_t;

  localparam int ICACHE_WORD_BYTES = 4;

  // Clears the byte-offset bits of an address; line_bytes must be a power of two.
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int unsigned line_bytes);
    return addr & ~(64'(line_bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_refill_engine_if.sv
// Cache-side and memory-side signal bundle of the refill engine; the engine takes the master view.
interface icache_refill_engine_if #(
  parameter int B      = 64,
  parameter int ADDR_W = 32
);
  localparam int IDX_W = $clog2(B / 4);

  logic              miss_i;
  logic [ADDR_W-1:0] miss_addr_i;
  logic              ic_repl_permit_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_req_addr_o;
  logic              mem_rsp_valid_i;
  logic [31:0]       mem_rsp_data_i;
  logic              rep_wr_en_o;
  logic [IDX_W-1:0]  rep_word_idx_o;
  logic [31:0]       rep_data_o;
  logic              rep_done_o;
  logic              rep_busy_o;
  logic [31:0]       perf_refills_o;
  logic [31:0]       perf_stall_o;

  modport master (
    input  miss_i, miss_addr_i, ic_repl_permit_i, mem_req_ready_i,
           mem_rsp_valid_i, mem_rsp_data_i,
    output mem_req_valid_o, mem_req_addr_o, rep_wr_en_o, rep_word_idx_o,
           rep_data_o, rep_done_o, rep_busy_o, perf_refills_o, perf_stall_o
  );

  modport slave (
    output miss_i, miss_addr_i, ic_repl_permit_i, mem_req_ready_i,
           mem_rsp_valid_i, mem_rsp_data_i,
    input  mem_req_valid_o, mem_req_addr_o, rep_wr_en_o, rep_word_idx_o,
           rep_data_o, rep_done_o, rep_busy_o, perf_refills_o, perf_stall_o
  );

endinterface

// File: rtl/refill_perf_ctr.sv
// 32-bit event counter that sticks at all-ones instead of wrapping; clear wins over increment.
module refill_perf_ctr (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_inc,
  input  logic        i_clr,
  output logic [31:0] o_count
);

  logic [31:0] r_count;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/icache_refill_engine.sv
// I-cache line refill engine: one aligned burst read per permitted miss, words streamed into the line.
// Define ICACHE_REFILL_PERF_EN to build the refill/busy-cycle performance counters.
module icache_refill_engine
  import icache_pkg::*;
#(
  parameter int B      = 64,
  parameter int ADDR_W = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  icache_refill_engine_if.master bus
);

  localparam int W     = B / ICACHE_WORD_BYTES;
  localparam int IDX_W = $clog2(W);

  refill_state_t     r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_drain, w_drain_nxt;
  logic [ADDR_W-1:0] r_base, w_base_nxt;

  logic              w_req_valid;
  logic              w_wr_en;
  logic              w_done;
  logic              w_busy;
  logic [ADDR_W-1:0] w_aligned;

  assign w_aligned = ADDR_W'(line_align(64'(bus.miss_addr_i), B));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= 1'b0;
      r_base  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_drain <= w_drain_nxt;
      r_base  <= w_base_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    w_base_nxt  = r_base;
    w_req_valid = 1'b0;
    w_wr_en     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.miss_i && bus.ic_repl_permit_i) begin
          w_base_nxt  = w_aligned;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        // A withdrawn permit (redirect) cancels before the memory ever sees the request.
        if (!bus.ic_repl_permit_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_req_valid = 1'b1;
          if (bus.mem_req_ready_i) begin
            w_cnt_nxt   = '0;
            w_state_nxt = FILL;
          end
        end
      end
      FILL: begin
        // Memory is committed to the whole burst, so a lost permit only stops the writes.
        if (!bus.ic_repl_permit_i) begin
          w_drain_nxt = 1'b1;
        end
        if (bus.mem_rsp_valid_i) begin
          w_wr_en   = bus.ic_repl_permit_i && !r_drain;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == IDX_W'(W - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_done      = !r_drain;
        w_drain_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy = (r_state != IDLE);

  assign bus.mem_req_valid_o = w_req_valid;
  assign bus.mem_req_addr_o  = r_base;
  assign bus.rep_wr_en_o     = w_wr_en;
  assign bus.rep_word_idx_o  = r_cnt;
  assign bus.rep_data_o      = w_wr_en ? bus.mem_rsp_data_i : 32'd0;
  assign bus.rep_done_o      = w_done;
  assign bus.rep_busy_o      = w_busy;

`ifdef ICACHE_REFILL_PERF_EN
  refill_perf_ctr u_refills_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_inc   (w_done),
    .i_clr   (1'b0),
    .o_count (bus.perf_refills_o)
  );

  refill_perf_ctr u_stall_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_inc   (w_busy),
    .i_clr   (1'b0),
    .o_count (bus.perf_stall_o)
  );
`else
  assign bus.perf_refills_o = 32'd0;
  assign bus.perf_stall_o   = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill_engine.sv
// Directed and randomized refills checked against a transaction-level model of the refill engine.
module tb_icache_refill_engine;

  localparam int B      = 64;
  localparam int ADDR_W = 32;
  localparam int W      = B / 4;
  localparam int IDX_W  = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_refill_engine_if #(.B(B), .ADDR_W(ADDR_W)) bus ();

  icache_refill_engine #(.B(B), .ADDR_W(ADDR_W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed cache-side writes, done pulses and accepted requests.
  logic [IDX_W-1:0]  wr_idx_q[$];
  logic [31:0]       wr_dat_q[$];
  int                done_n   = 0;
  int                done_cyc = 0;
  int                req_n    = 0;
  logic [ADDR_W-1:0] req_addr = '0;

  always @(negedge clk) begin
    if (bus.rep_wr_en_o) begin
      wr_idx_q.push_back(bus.rep_word_idx_o);
      wr_dat_q.push_back(bus.rep_data_o);
    end
    if (bus.rep_done_o) begin
      done_n++;
      done_cyc = cyc;
    end
    if (bus.mem_req_valid_o && bus.mem_req_ready_i) begin
      req_n++;
      req_addr = bus.mem_req_addr_o;
    end
  end

  // Model state for the performance counters.
  int model_refills = 0;
  int model_busy    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    wr_idx_q.delete();
    wr_dat_q.delete();
    done_n = 0;
    req_n  = 0;
  endtask

  function automatic logic [ADDR_W-1:0] model_align(input logic [ADDR_W-1:0] a);
    return (a / ADDR_W'(B)) * ADDR_W'(B);
  endfunction

  // One miss: permit held off pdelay cycles, gap idle cycles before each word, permit lost from word drop on.
  task automatic refill(input logic [ADDR_W-1:0] addr, input int gap, input int drop, input int pdelay);
    logic [31:0] words[W];
    int acc;
    int exp_wr;
    bit exp_done;
    clr_mon();
    for (int i = 0; i < W; i++) words[i] = $urandom;
    exp_wr   = (drop < W) ? drop : W;
    exp_done = (drop >= W);

    bus.miss_i           = 1'b1;
    bus.miss_addr_i      = addr;
    bus.ic_repl_permit_i = 1'b0;
    bus.mem_req_ready_i  = 1'b1;
    for (int k = 0; k < pdelay; k++) begin
      @(negedge clk);
      chk("no_busy_wo_permit", 64'(bus.rep_busy_o), 64'd0);
      step();
    end
    bus.ic_repl_permit_i = 1'b1;
    acc = cyc;
    step();
    bus.miss_i      = 1'b0;
    bus.miss_addr_i = $urandom;
    @(negedge clk);
    chk("req_valid", 64'(bus.mem_req_valid_o), 64'd1);
    chk("req_addr", 64'(bus.mem_req_addr_o), 64'(model_align(addr)));
    for (int i = 0; i < W; i++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        bus.mem_rsp_valid_i = 1'b0;
      end
      step();
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = words[i];
      if (i >= drop) bus.ic_repl_permit_i = 1'b0;
    end
    step();
    bus.mem_rsp_valid_i  = 1'b0;
    bus.mem_rsp_data_i   = '0;
    bus.ic_repl_permit_i = 1'b1;
    bus.mem_req_ready_i  = 1'b0;
    @(negedge clk);
    chk("done_pulse", 64'(bus.rep_done_o), 64'(exp_done));
    step();
    @(negedge clk);
    chk("idle_after", 64'(bus.rep_busy_o), 64'd0);
    step();

    chk("req_count", 64'(req_n), 64'd1);
    chk("req_addr_mon", 64'(req_addr), 64'(model_align(addr)));
    chk("wr_count", 64'(wr_idx_q.size()), 64'(exp_wr));
    for (int i = 0; i < exp_wr && i < wr_idx_q.size(); i++) begin
      chk("wr_idx", 64'(wr_idx_q[i]), 64'(i));
      chk("wr_data", 64'(wr_dat_q[i]), 64'(words[i]));
    end
    chk("done_count", 64'(done_n), 64'(exp_done));
    if (exp_done) chk("done_cycle", 64'(done_cyc - acc), 64'(2 + W * (gap + 1)));
    model_busy += 2 + W * (gap + 1);
    if (exp_done) model_refills++;
  endtask

  initial begin
    bus.miss_i           = 1'b0;
    bus.miss_addr_i      = '0;
    bus.ic_repl_permit_i = 1'b0;
    bus.mem_req_ready_i  = 1'b0;
    bus.mem_rsp_valid_i  = 1'b0;
    bus.mem_rsp_data_i   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(bus.rep_busy_o), 64'd0);
    chk("rst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("rst_req_addr", 64'(bus.mem_req_addr_o), 64'd0);
    chk("rst_wr_en", 64'(bus.rep_wr_en_o), 64'd0);
    chk("rst_idx", 64'(bus.rep_word_idx_o), 64'd0);
    chk("rst_done", 64'(bus.rep_done_o), 64'd0);
    chk("rst_perf_refills", 64'(bus.perf_refills_o), 64'd0);
    chk("rst_perf_stall", 64'(bus.perf_stall_o), 64'd0);
    rst = 1'b0;
    step();

    // Stray response while idle must not write.
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("idle_rsp_ignored", 64'(bus.rep_wr_en_o), 64'd0);
    step();
    bus.mem_rsp_valid_i = 1'b0;

    refill(32'h0000_1234, 0, W, 0);
    refill($urandom, 0, W, 5);

    // Permit withdrawn while the request is stalled.
    clr_mon();
    bus.miss_i           = 1'b1;
    bus.miss_addr_i      = 32'h0000_5678;
    bus.ic_repl_permit_i = 1'b1;
    bus.mem_req_ready_i  = 1'b0;
    step();
    bus.miss_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
      chk("stall_req_addr", 64'(bus.mem_req_addr_o), 64'h0000_5640);
      step();
    end
    bus.ic_repl_permit_i = 1'b0;
    bus.mem_req_ready_i  = 1'b1;
    @(negedge clk);
    chk("abort_valid_drop", 64'(bus.mem_req_valid_o), 64'd0);
    step();
    bus.mem_req_ready_i  = 1'b0;
    bus.ic_repl_permit_i = 1'b1;
    @(negedge clk);
    chk("abort_idle", 64'(bus.rep_busy_o), 64'd0);
    chk("abort_no_req", 64'(req_n), 64'd0);
    chk("abort_no_wr", 64'(wr_idx_q.size()), 64'd0);
    model_busy += 3;
    step();

    refill($urandom, 0, 6, 0);
    refill($urandom, 2, W, 0);

    for (int t = 0; t < 6; t++) begin
      int gap_r;
      int drop_r;
      int pd_r;
      gap_r  = int'($urandom_range(0, 2));
      drop_r = ($urandom_range(0, 1) == 0) ? W : int'($urandom_range(0, W - 1));
      pd_r   = int'($urandom_range(0, 3));
      refill($urandom, gap_r, drop_r, pd_r);
    end

`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_refills_run", 64'(bus.perf_refills_o), 64'(model_refills));
    chk("perf_stall_run", 64'(bus.perf_stall_o), 64'(model_busy));
`endif

    // Asynchronous reset in the middle of a burst.
    clr_mon();
    bus.miss_i           = 1'b1;
    bus.miss_addr_i      = 32'h0000_9ABC;
    bus.ic_repl_permit_i = 1'b1;
    bus.mem_req_ready_i  = 1'b1;
    step();
    bus.miss_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      bus.mem_rsp_valid_i = 1'b1;
      bus.mem_rsp_data_i  = $urandom;
    end
    step();
    bus.mem_rsp_data_i = 32'h1357_9BDF;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.rep_busy_o), 64'd0);
    chk("arst_wr_en", 64'(bus.rep_wr_en_o), 64'd0);
    chk("arst_data", 64'(bus.rep_data_o), 64'd0);
    chk("arst_idx", 64'(bus.rep_word_idx_o), 64'd0);
    chk("arst_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
    chk("arst_req_addr", 64'(bus.mem_req_addr_o), 64'd0);
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_wr_count", 64'(wr_idx_q.size()), 64'd7);
    chk("arst_no_done", 64'(done_n), 64'd0);

    model_refills = 0;
    model_busy    = 0;
    refill($urandom, 0, W, 0);
    refill($urandom, 0, W, 0);
`ifdef ICACHE_REFILL_PERF_EN
    chk("perf_refills", 64'(bus.perf_refills_o), 64'(model_refills));
    chk("perf_stall", 64'(bus.perf_stall_o), 64'(model_busy));
`else
    chk("perf_refills_tied", 64'(bus.perf_refills_o), 64'd0);
    chk("perf_stall_tied", 64'(bus.perf_stall_o), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
